// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan driver and decoder.
//   - segment patterns for status glyphs, bit order {g,f,e,d,c,b,a}
//   - glyph index enum (codes with bit4=1 select a glyph by this index)
//   - per-digit register-file entry type and its blank value
//   - hex nibble to segment helper
package seg7_pkg;

  localparam int CODE_W = 5;
  localparam logic [CODE_W-1:0] BLANK_CODE = 5'h17;

  localparam logic [6:0] LETRA_A      = 7'h77;
  localparam logic [6:0] LETRA_F      = 7'h71;
  localparam logic [6:0] LETRA_P      = 7'h73;
  localparam logic [6:0] NIVEL_ALTO   = 7'h5F;
  localparam logic [6:0] NIVEL_NORMAL = 7'h54;
  localparam logic [6:0] NIVEL_BAIXO  = 7'h7C;
  localparam logic [6:0] DESCALIBRADO = 7'h5E;
  localparam logic [6:0] BLANK        = 7'h00;
  localparam logic [6:0] DASH         = 7'h40;

  typedef enum logic [3:0] {
    GLYPH_A            = 4'd0,
    GLYPH_F            = 4'd1,
    GLYPH_P            = 4'd2,
    GLYPH_NIVEL_ALTO   = 4'd3,
    GLYPH_NIVEL_NORMAL = 4'd4,
    GLYPH_NIVEL_BAIXO  = 4'd5,
    GLYPH_DESCALIBRADO = 4'd6,
    GLYPH_BLANK        = 4'd7,
    GLYPH_DASH         = 4'd8
  } glyph_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              dp;
    logic              blink;
  } entry_t;

  localparam entry_t ENTRY_BLANK = {BLANK_CODE, 1'b0, 1'b0};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      4'hF:    pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 5-bit digit code to 7-segment pattern.
// Ports:
//   code    in  5  bit4=0: hex nibble in bits[3:0]; bit4=1: glyph index
//   pattern out 7  {g,f,e,d,c,b,a}, active-high; unused glyph indices blank
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [6:0]        pattern
);

  // Select hex or glyph table from the code's mode bit.
  always_comb begin
    pattern = BLANK;
    if (code[4]) begin
      case (glyph_e'(code[3:0]))
        GLYPH_A:            pattern = LETRA_A;
        GLYPH_F:            pattern = LETRA_F;
        GLYPH_P:            pattern = LETRA_P;
        GLYPH_NIVEL_ALTO:   pattern = NIVEL_ALTO;
        GLYPH_NIVEL_NORMAL: pattern = NIVEL_NORMAL;
        GLYPH_NIVEL_BAIXO:  pattern = NIVEL_BAIXO;
        GLYPH_DESCALIBRADO: pattern = DESCALIBRADO;
        GLYPH_BLANK:        pattern = BLANK;
        GLYPH_DASH:         pattern = DASH;
        default:            pattern = BLANK;
      endcase
    end else begin
      pattern = hex_to_seg(code[3:0]);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for NDIGITS 7-segment digits.
// Ports:
//   clk_2      in   system clock
//   reset      in   synchronous active-high reset
//   wr_en      in   write strobe; stores {wr_code, wr_dp, wr_blink} at wr_idx
//   wr_idx     in   target digit (writes with wr_idx >= NDIGITS are dropped)
//   wr_code    in   5-bit digit code (see seg7_decode)
//   wr_dp      in   decimal point for the target digit
//   wr_blink   in   blink enable for the target digit
//   clear      in   blank every entry; overrides a simultaneous write
//   seg        out  {dp,g,f,e,d,c,b,a}, active-high, registered
//   dig_sel    out  one-hot digit enable, registered
//   frame_done out  one-cycle pulse as the last digit's dwell ends
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NDIGITS   = 4,
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic                                          clk_2,
  input  logic                                          reset,
  input  logic                                          wr_en,
  input  logic [((NDIGITS > 1) ? $clog2(NDIGITS) : 1)-1:0] wr_idx,
  input  logic [CODE_W-1:0]                             wr_code,
  input  logic                                          wr_dp,
  input  logic                                          wr_blink,
  input  logic                                          clear,
  output logic [7:0]                                    seg,
  output logic [NDIGITS-1:0]                            dig_sel,
  output logic                                          frame_done
);

  localparam int IDX_W  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PCNT_W-1:0] pcnt;
  logic [IDX_W-1:0]  ptr;
  logic [FCNT_W-1:0] fcnt;
  logic              phase;
  entry_t            entries [NDIGITS];

  logic   pcnt_wrap;
  logic   frame_wrap;
  logic   blink_wrap;
  logic   wr_ok;
  entry_t cur;
  logic [6:0] dec_pattern;
  logic [7:0] seg_next;

  assign pcnt_wrap  = (pcnt == PCNT_W'(SCAN_DIV - 1));
  assign frame_wrap = pcnt_wrap && (ptr == IDX_W'(NDIGITS - 1));
  assign blink_wrap = frame_wrap && (fcnt == FCNT_W'(BLINK_DIV - 1));
  assign wr_ok      = wr_en && (int'(wr_idx) < NDIGITS);
  assign cur        = entries[ptr];

  seg7_decode u_decode (
    .code    (cur.code),
    .pattern (dec_pattern)
  );

  // Blinking digits go fully dark (dp included) in the odd blink phase.
  always_comb begin
    seg_next = 8'h00;
    if (cur.blink && phase) begin
      seg_next = 8'h00;
    end else begin
      seg_next = {cur.dp, dec_pattern};
    end
  end

  // Scan prescaler, digit pointer, frame counter and blink phase.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      pcnt  <= '0;
      ptr   <= '0;
      fcnt  <= '0;
      phase <= 1'b0;
    end else begin
      pcnt <= pcnt_wrap ? '0 : pcnt + PCNT_W'(1);
      if (frame_wrap) begin
        ptr  <= '0;
        fcnt <= blink_wrap ? '0 : fcnt + FCNT_W'(1);
      end else if (pcnt_wrap) begin
        ptr <= ptr + IDX_W'(1);
      end
      if (blink_wrap) begin
        phase <= ~phase;
      end
    end
  end

  // Per-digit register file; clear beats a same-cycle write.
  always_ff @(posedge clk_2) begin
    if (reset || clear) begin
      for (int i = 0; i < NDIGITS; i++) begin
        entries[i] <= ENTRY_BLANK;
      end
    end else if (wr_ok) begin
      entries[wr_idx] <= {wr_code, wr_dp, wr_blink};
    end
  end

  // Registered outputs follow the pointer with one cycle of latency.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      seg        <= 8'h00;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_next;
      dig_sel    <= NDIGITS'(1) << ptr;
      frame_done <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int N = 4;
  localparam int S = 4;
  localparam int B = 2;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_idx = 2'd0;
  logic [4:0] wr_code = 5'd0;
  logic       wr_dp = 1'b0;
  logic       wr_blink = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] seg;
  logic [3:0] dig_sel;
  logic       frame_done;

  // Second instance with three digits, used for the out-of-range write case.
  logic       wr_en3 = 1'b0;
  logic [1:0] wr_idx3 = 2'd0;
  logic [4:0] wr_code3 = 5'd0;
  logic [7:0] seg3;
  logic [2:0] dig_sel3;
  logic       frame_done3;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk_2 = ~clk_2;

  seg7_scan_driver #(.NDIGITS(N), .SCAN_DIV(S), .BLINK_DIV(B)) u_dut (
    .clk_2(clk_2), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_code(wr_code), .wr_dp(wr_dp), .wr_blink(wr_blink), .clear(clear),
    .seg(seg), .dig_sel(dig_sel), .frame_done(frame_done)
  );

  seg7_scan_driver #(.NDIGITS(3), .SCAN_DIV(S), .BLINK_DIV(B)) u_dut3 (
    .clk_2(clk_2), .reset(reset), .wr_en(wr_en3), .wr_idx(wr_idx3),
    .wr_code(wr_code3), .wr_dp(1'b0), .wr_blink(1'b0), .clear(1'b0),
    .seg(seg3), .dig_sel(dig_sel3), .frame_done(frame_done3)
  );

  // Reference model: outputs derived from the cycle count since reset.
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [6:0] gly_tab [16] = '{7'h77, 7'h71, 7'h73, 7'h5F, 7'h54, 7'h7C, 7'h5E, 7'h00,
                               7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  int         m_t;
  logic [4:0] m_code [N];
  logic       m_dp [N];
  logic       m_blink [N];
  logic [7:0] exp_seg;
  logic [3:0] exp_dig;
  logic       exp_fd;

  function automatic logic [7:0] ref_seg(input int t);
    int digit;
    int ph;
    logic [6:0] pat;
    digit = (t / S) % N;
    ph    = ((t / (S * N)) / B) % 2;
    pat   = m_code[digit][4] ? gly_tab[m_code[digit][3:0]] : hex_tab[m_code[digit][3:0]];
    if (m_blink[digit] && ph == 1) return 8'h00;
    return {m_dp[digit], pat};
  endfunction

  always @(posedge clk_2) begin
    if (reset) begin
      m_t     <= 0;
      exp_seg <= 8'h00;
      exp_dig <= 4'b0000;
      exp_fd  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        m_code[i]  <= 5'h17;
        m_dp[i]    <= 1'b0;
        m_blink[i] <= 1'b0;
      end
    end else begin
      exp_seg <= ref_seg(m_t);
      exp_dig <= 4'(1 << ((m_t / S) % N));
      exp_fd  <= (((m_t + 1) % (S * N)) == 0);
      m_t     <= m_t + 1;
      if (clear) begin
        for (int i = 0; i < N; i++) begin
          m_code[i]  <= 5'h17;
          m_dp[i]    <= 1'b0;
          m_blink[i] <= 1'b0;
        end
      end else if (wr_en && int'(wr_idx) < N) begin
        m_code[wr_idx]  <= wr_code;
        m_dp[wr_idx]    <= wr_dp;
        m_blink[wr_idx] <= wr_blink;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk_2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_2);
      chk_cnt++;
      if (seg !== 8'h00 || dig_sel !== 4'b0000 || frame_done !== 1'b0)
        $display("FAIL reset_hold: seg=%h dig_sel=%b frame_done=%b, required 00/0000/0", seg, dig_sel, frame_done);
      else pass_cnt++;
    end
    reset = 1'b0;
    @(negedge clk_2);
    chk_cnt++;
    if (dig_sel !== 4'b0001 || seg !== 8'h00)
      $display("FAIL first_free: seg=%h dig_sel=%b, required 00/0001", seg, dig_sel);
    else pass_cnt++;
  endtask

  task automatic test_scan();
    // k = edges since reset release; the check above consumed k=1.
    for (int k = 2; k <= 49; k++) begin
      @(negedge clk_2);
      chk_cnt++;
      if (dig_sel !== 4'(1 << (((k - 1) / S) % N)) || frame_done !== ((k % (S * N)) == 0) || seg !== 8'h00)
        $display("FAIL scan k=%0d: dig_sel=%b frame_done=%b seg=%h, required %b/%0d/00", k, dig_sel, frame_done, seg,
                 4'(1 << (((k - 1) / S) % N)), (k % (S * N)) == 0);
      else pass_cnt++;
    end
  endtask

  task automatic test_writes();
    logic [4:0] codes [4] = '{5'h07, 5'h0A, 5'h10, 5'h14};
    logic [7:0] want  [4] = '{8'h07, 8'h77, 8'h77, 8'h54};
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_idx = 2'(i); wr_code = codes[i]; wr_dp = 1'b0; wr_blink = 1'b0;
      @(negedge clk_2);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_2);
      chk_cnt++;
      if (seg !== exp_seg || dig_sel !== exp_dig || frame_done !== exp_fd)
        $display("FAIL writes_model: seg=%h dig_sel=%b fd=%b, required %h/%b/%b", seg, dig_sel, frame_done, exp_seg, exp_dig, exp_fd);
      else pass_cnt++;
      if (i >= 16) begin
        for (int d = 0; d < 4; d++) begin
          if (dig_sel == 4'(1 << d)) begin
            chk_cnt++;
            if (seg !== want[d]) $display("FAIL writes_digit%0d: seg=%h, required %h", d, seg, want[d]);
            else pass_cnt++;
          end
        end
      end
    end
  endtask

  task automatic test_dp();
    wr_en = 1'b1; wr_idx = 2'd2; wr_code = 5'h05; wr_dp = 1'b1; wr_blink = 1'b0;
    @(negedge clk_2);
    wr_en = 1'b0; wr_dp = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_2);
      if (i >= 16 && dig_sel == 4'b0100) begin
        chk_cnt++;
        if (seg !== 8'hED) $display("FAIL dp_digit2: seg=%h, required ED", seg);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_blink();
    reset = 1'b1;
    @(negedge clk_2);
    reset = 1'b0;
    wr_en = 1'b1; wr_idx = 2'd1; wr_code = 5'h0B; wr_dp = 1'b0; wr_blink = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk_2);
      chk_cnt++;
      if (seg !== exp_seg || dig_sel !== exp_dig || frame_done !== exp_fd)
        $display("FAIL blink_model k=%0d: seg=%h dig_sel=%b fd=%b, required %h/%b/%b", k, seg, dig_sel, frame_done, exp_seg, exp_dig, exp_fd);
      else pass_cnt++;
      if (dig_sel == 4'b0010) begin
        chk_cnt++;
        if (seg !== (((((k - 1) / 16) / 2) % 2) == 1 ? 8'h00 : 8'h7C))
          $display("FAIL blink_digit1 frame=%0d: seg=%h, required %h", (k - 1) / 16, seg,
                   (((((k - 1) / 16) / 2) % 2) == 1 ? 8'h00 : 8'h7C));
        else pass_cnt++;
      end
      if (dig_sel == 4'b1000) begin
        chk_cnt++;
        if (seg !== 8'h73) $display("FAIL blink_other_digit3: seg=%h, required 73", seg);
        else pass_cnt++;
      end
      if (k == 1) begin
        wr_idx = 2'd3; wr_code = 5'h12; wr_blink = 1'b0;
      end else begin
        wr_en = 1'b0; wr_blink = 1'b0;
      end
    end
  endtask

  task automatic test_clear();
    clear = 1'b1; wr_en = 1'b1; wr_idx = 2'd0; wr_code = 5'h03;
    @(negedge clk_2);
    clear = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk_2);
      if (i >= 1) begin
        chk_cnt++;
        if (seg !== 8'h00) $display("FAIL clear_blank: seg=%h dig_sel=%b, required 00", seg, dig_sel);
        else pass_cnt++;
      end
    end
    wr_en = 1'b1; wr_idx = 2'd3; wr_code = 5'h0E;
    @(negedge clk_2);
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_2);
      if (i >= 16) begin
        chk_cnt++;
        if (seg !== (dig_sel == 4'b1000 ? 8'h79 : 8'h00))
          $display("FAIL clear_then_write3: seg=%h dig_sel=%b, required %h", seg, dig_sel, (dig_sel == 4'b1000 ? 8'h79 : 8'h00));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_out_of_range();
    int fd_seen;
    fd_seen = 0;
    wr_en3 = 1'b1; wr_idx3 = 2'd3; wr_code3 = 5'h08;
    @(negedge clk_2);
    wr_en3 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_2);
      if (frame_done3) fd_seen++;
      chk_cnt++;
      if (seg3 !== 8'h00 || !(dig_sel3 == 3'b001 || dig_sel3 == 3'b010 || dig_sel3 == 3'b100))
        $display("FAIL oor_ignored: seg3=%h dig_sel3=%b, required 00 and one-hot", seg3, dig_sel3);
      else pass_cnt++;
    end
    chk_cnt++;
    if (fd_seen != 2) $display("FAIL oor_frame_count: pulses=%0d, required 2", fd_seen);
    else pass_cnt++;
    wr_en3 = 1'b1; wr_idx3 = 2'd2; wr_code3 = 5'h01;
    @(negedge clk_2);
    wr_en3 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_2);
      if (i >= 12) begin
        chk_cnt++;
        if (seg3 !== (dig_sel3 == 3'b100 ? 8'h06 : 8'h00))
          $display("FAIL oor_valid_write: seg3=%h dig_sel3=%b, required %h", seg3, dig_sel3, (dig_sel3 == 3'b100 ? 8'h06 : 8'h00));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_2);
      chk_cnt++;
      if (seg !== exp_seg || dig_sel !== exp_dig || frame_done !== exp_fd)
        $display("FAIL random i=%0d: seg=%h dig_sel=%b fd=%b, required %h/%b/%b", i, seg, dig_sel, frame_done, exp_seg, exp_dig, exp_fd);
      else pass_cnt++;
      wr_en    = 1'($urandom_range(0, 1));
      wr_idx   = 2'($urandom_range(0, 3));
      wr_code  = 5'($urandom_range(0, 31));
      wr_dp    = 1'($urandom_range(0, 1));
      wr_blink = 1'($urandom_range(0, 1));
      clear    = ($urandom_range(0, 39) == 0);
    end
    wr_en = 1'b0; clear = 1'b0; wr_dp = 1'b0; wr_blink = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Put a visible digit everywhere so the post-reset blanking is observable.
    for (int d = 0; d < 4; d++) begin
      wr_en = 1'b1; wr_idx = 2'(d); wr_code = 5'h08;
      @(negedge clk_2);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 16 && (m_t % 16) != 9; i++) @(negedge clk_2);
    reset = 1'b1;
    @(negedge clk_2);
    chk_cnt++;
    if (seg !== 8'h00 || dig_sel !== 4'b0000 || frame_done !== 1'b0)
      $display("FAIL reset_mid: seg=%h dig_sel=%b fd=%b, required 00/0000/0", seg, dig_sel, frame_done);
    else pass_cnt++;
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_2);
      chk_cnt++;
      if (seg !== 8'h00 || dig_sel !== 4'(1 << (((k - 1) / S) % N)) || frame_done !== ((k % 16) == 0))
        $display("FAIL after_reset_mid k=%0d: seg=%h dig_sel=%b fd=%b, required 00/%b/%0d", k, seg, dig_sel, frame_done,
                 4'(1 << (((k - 1) / S) % N)), (k % 16) == 0);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_writes();
    test_dp();
    test_blink();
    test_clear();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for a bank of 7-segment digits. Holds a per-digit register file of hex digits or status glyphs, with decimal point and blink flag. Scans digits at a programmable rate, so one shared `seg` bus serves NDIGITS displays. Sits between the status/datapath logic in `top` (which writes codes) and the board's segment and digit-select pins.

## Interface
- `NDIGITS`, 4: number of digits scanned; ≥1.
- `SCAN_DIV`, 4: clock cycles each digit stays selected; ≥1.
- `BLINK_DIV`, 8: full frames per blink half-period; ≥1.
- `clk_2`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe for one digit entry.
- `wr_idx`  in  $clog2(NDIGITS) (min 1)  target digit.
- `wr_code`  in  5  digit code: bit4=0 → hex nibble bits[3:0]; bit4=1 → glyph index bits[3:0].
- `wr_dp`  in  1  decimal point for target digit.
- `wr_blink`  in  1  blink enable for target digit.
- `clear`  in  1  blank all entries.
- `seg`  out  8  {dp,g,f,e,d,c,b,a}, active-high.
- `dig_sel`  out  NDIGITS  one-hot active-high digit enable.
- `frame_done`  out  1  one-cycle pulse when the last digit's dwell ends.

## Operation
- Entry per digit: {code[4:0], dp, blink}. Reset and `clear` set every entry to {5'h17 (blank glyph), 0, 0}.
- Write: `wr_en` high at an edge stores {wr_code, wr_dp, wr_blink} into entry `wr_idx`. If `wr_idx` ≥ NDIGITS, the write is ignored. If `clear` and `wr_en` are both high, `clear` wins and the write is dropped.
- Hex decode, 0–F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Glyph decode, index 0–8: A=77, F=71, P=73, a=5F, n=54, b=7C, d=5E, blank=00, '-'=40. Indices 9–15 decode to 00.
- `seg[7]` = entry dp, ORed onto the decoded pattern.
- Scan: prescaler `pcnt` counts 0..SCAN_DIV-1. When it wraps, pointer `ptr` advances, wrapping NDIGITS-1 → 0. `frame_done` is registered and pulses in the cycle after `ptr` wraps to 0.
- Blink: frame counter 0..BLINK_DIV-1 advances on each frame wrap. At its wrap, `phase` toggles. When an entry has blink=1 and `phase`=1, `seg` = 00 including dp; `dig_sel` is still asserted.

## Timing
- All outputs are registered. Every cycle: `dig_sel` ← onehot(`ptr`), `seg` ← decode(entry[`ptr`]) with blink masking.
- Reset values: `seg`=00, `dig_sel`=0, `frame_done`=0, `ptr`=0, `pcnt`=0, frame counter 0, `phase`=0.
- First cycle after reset deasserts: `dig_sel`=0001, `seg`=00.
- Latency:
  - `ptr` change → outputs: 1 cycle.
  - `wr_en` sampled at edge k → entry updated at edge k → visible on `seg` after edge k+1, provided that digit is selected.
- Dwell: exactly SCAN_DIV cycles per digit. Frame: NDIGITS·SCAN_DIV cycles. Blink half-period: BLINK_DIV·NDIGITS·SCAN_DIV cycles.
- SCAN_DIV=1: `ptr` advances every cycle. NDIGITS=1: `dig_sel` is constantly 1 and `frame_done` pulses every SCAN_DIV cycles.
- Reset mid-scan or mid-blink: all counters, `phase` and entries return to reset values at that edge. There is no partial frame pulse.
- Writes never stall or disturb the scan counters.

## Structure
- Package `seg7_pkg`:
  - segment constants (LETRA_A/F/P, NIVEL_ALTO/NORMAL/BAIXO, DESCALIBRADO, BLANK, DASH);
  - glyph index enum;
  - code width 5;
  - blank code 5'h17.
- Sub-module `seg7_decode`: purely combinational 5-bit code → 7-bit pattern. It is also reusable standalone by `top`.
- `seg7_scan_driver` holds: register file, prescaler, pointer, frame/blink counters, output registers.

## Test plan
Bench parameters: NDIGITS=4, SCAN_DIV=4, BLINK_DIV=2.
- Reset held 3 cycles, then released → `seg`=00, `dig_sel`=0 during reset. First free cycle `dig_sel`=0001. Dwell is 4 cycles per digit, order 0001→0010→0100→1000→0001. `frame_done` pulses once every 16 cycles.
- Write codes 0x07, 0x0A, 0x10, 0x14 to digits 0–3 → `seg` reads 07, 77, 77, 54 while the respective `dig_sel` bit is high.
- Write digit 2: code 0x05, dp=1 → `seg`=ED when `dig_sel`=0100.
- Digit 1 with blink=1, code 0x0B → `seg`=7C for frames 0–1, 00 for frames 2–3, then 7C again. Other digits are unaffected.
- `clear` and `wr_en` (idx 0, code 0x03) in the same cycle → all digits 00. A write with `wr_idx`=3 takes effect; `wr_idx` out of range (NDIGITS=3 build, idx 3) changes nothing.
- Reset asserted at cycle 9 of a frame → next cycle all outputs at reset values. Written entries read blank afterwards.
